iob_ram_tdp_arb: RTL and testbench
==================================

Name: iob_ram_tdp_arb

Overview:
- Round-robin arbiter that shares one port of the true-dual-port RAM (iob_ram_tdp) between N_REQ requesters on a single clock domain.
- Each requester issues single-word reads/writes with a valid/ready handshake. Read data returns on a per-requester response strobe one cycle after acceptance.
- Instantiated once per RAM port that must be shared; the other RAM port stays free for a dedicated master.

Parameters:
N_REQ, 2, number of requesters (>=2)
DATA_W, 8, RAM word width
ADDR_W, 4, RAM address width (depth 2**ADDR_W)

Ports:
clk  input  1  system clock; also drives the RAM port clock
rst  input  1  synchronous, active-high reset
req_valid  input  N_REQ  per-requester request valid
req_ready  output  N_REQ  per-requester grant; transfer when valid&ready
req_we  input  N_REQ  per-requester write enable (1=write, 0=read)
req_addr  input  N_REQ*ADDR_W  flattened addresses, requester i at [i*ADDR_W +: ADDR_W]
req_wdata  input  N_REQ*DATA_W  flattened write data, same packing
resp_valid  output  N_REQ  one-hot read-data strobe
resp_rdata  output  DATA_W  read data, valid only when resp_valid!=0
ram_en  output  1  RAM port enable
ram_we  output  1  RAM port write enable
ram_addr  output  ADDR_W  RAM port address
ram_din  output  DATA_W  RAM port write data
ram_dout  input  DATA_W  RAM port registered read data

Behaviour:
- Reset (clk edge with rst=1): priority pointer ptr=0; resp_valid=0; lock state=IDLE. During rst: req_ready=0, ram_en=0.
- Grant is combinational within the cycle. Among asserted req_valid bits, the first index at or after ptr (wrapping modulo N_REQ) wins. Exactly one req_ready is high when any req_valid is high; none otherwise.
- ram_en = |req_valid (outside reset). ram_we/ram_addr/ram_din come from the granted requester. When no request: ram_en=0, ram_we=0, ram_addr=0, ram_din=0.
- Pointer update: on every accepted transfer with granted index g, ptr <= (g+1) mod N_REQ. With no transfer, ptr holds.
- Requester rules: req_valid must not drop and req_we/addr/wdata must not change until req_ready is seen. Not asserting req_ready is never an error.
- Read latency: accepted read at cycle t -> resp_valid[g]=1 at cycle t+1 for exactly one cycle, with resp_rdata=ram_dout (RAM output register). resp_valid is registered. resp_rdata is a direct pass-through of ram_dout.
- Writes produce no response. A write and a subsequent read of the same address by any requester in back-to-back cycles returns the new data.
- Throughput: one transfer per cycle. Back-to-back reads from different requesters give consecutive one-hot resp_valid pulses.
- Simultaneous requests from all N_REQ requesters are served in index order starting at ptr, so each requester waits at most N_REQ-1 cycles.
- Reset mid-operation: a read accepted in the cycle rst is asserted gets no response; resp_valid is 0 the next cycle.
- Addresses wrap naturally within ADDR_W bits; no bounds checking.

Optional Feature:
Macro: IOB_RAM_TDP_ARB_LOCK_EN
- With the macro: adds input req_lock[N_REQ] and a two-state FSM (IDLE, LOCKED).
  - IDLE -> LOCKED when a transfer is accepted from g with req_lock[g]=1. The owner is recorded.
  - While LOCKED, only the owner can be granted; other valids wait.
  - LOCKED -> IDLE on the first cycle the owner has req_lock=0, or on rst.
  - ptr is updated only on the transfer that leaves LOCKED, or on normal unlocked transfers.
- Without the macro: no req_lock port and no FSM; pure round-robin.

Decomposition:
- Shared header iob_ram_tdp_arb.vh: FSM state encodings (ARB_IDLE=1'b0, ARB_LOCKED=1'b1) and the default width constants.
- Sub-module iob_rr_sel: combinational round-robin selector. Inputs request vector and ptr; outputs one-hot grant and binary index. Reusable elsewhere.

Test Plan:
- N_REQ=2, only req0 writes addr 0..15 with data 32+i, then reads them back -> resp_valid=2'b01 one cycle after each accept, resp_rdata=32+i.
- req0 and req1 assert valid continuously after reset (ptr=0), both reading addr 3 -> grants alternate 01,10,01,...; resp_valid alternates one cycle later.
- req1 writes addr 5 = 8'h40 in cycle t; req0 reads addr 5 in t+1 -> resp_rdata=8'h40 at t+2.
- Read accepted on the same edge rst rises -> resp_valid=0 next cycle; ptr=0; first grant after reset goes to req0 when both request.
- No req_valid for 10 cycles -> ram_en=0, req_ready=0, resp_valid=0 throughout; ptr unchanged.
- With IOB_RAM_TDP_ARB_LOCK_EN: req1 locks and reads 4 words while req0 valid -> req0 stalls all 4; req0 is granted the cycle after req1 drops lock.

Source files
------------

// File: rtl/iob_ram_tdp_arb_pkg.sv
// iob_ram_tdp_arb_pkg
// Shared definitions for the RAM port arbiter.
//   arb_state_e   : lock FSM state encoding (IDLE=0, LOCKED=1)
//   DEF_*         : default width constants used by the top-level parameters
//   idx_width()   : width of a binary requester index (at least one bit)
// The lock FSM is only built when IOB_RAM_TDP_ARB_LOCK_EN is defined.
package iob_ram_tdp_arb_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  localparam int DEF_N_REQ  = 2;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 4;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/iob_ram_tdp_arb_rr_sel.sv
// iob_rr_sel
// Combinational round-robin selector. The first asserted request at or
// after ptr (wrapping modulo N) wins.
// Ports:
//   req  [N]      : request vector
//   ptr  [IDX_W]  : priority pointer, must be < N
//   gnt  [N]      : one-hot grant, all zero when no request
//   idx  [IDX_W]  : binary index of the granted request (0 when none)
//   any           : at least one request is asserted
module iob_rr_sel #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  localparam logic [IDX_W:0] N_L = N[IDX_W:0];

  logic [IDX_W:0] cand;

  // Walk the N candidates starting at ptr. The sum ptr+off is below 2N,
  // so one conditional subtract is enough to wrap it.
  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int off = 0; off < N; off++) begin
      cand = {1'b0, ptr} + off[IDX_W:0];
      if (cand >= N_L) begin
        cand = cand - N_L;
      end
      if (!any && req[cand[IDX_W-1:0]]) begin
        any                    = 1'b1;
        gnt[cand[IDX_W-1:0]]   = 1'b1;
        idx                    = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/iob_ram_tdp_arb.sv
// iob_ram_tdp_arb
// Round-robin arbiter sharing one port of a true-dual-port RAM between
// N_REQ requesters. One single-word transfer per cycle; read data returns
// on a one-hot per-requester strobe one cycle after acceptance.
// Optional macro IOB_RAM_TDP_ARB_LOCK_EN adds req_lock and an IDLE/LOCKED
// FSM that lets one requester hold the port for a burst.
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   req_valid/req_ready [N]   : per-requester handshake
//   req_we [N]                : 1 = write, 0 = read
//   req_addr [N*ADDR_W]       : flattened addresses, requester i at [i*ADDR_W +: ADDR_W]
//   req_wdata [N*DATA_W]      : flattened write data, same packing
//   req_lock [N]              : (lock build only) hold the port after this transfer
//   resp_valid [N]            : one-hot read-data strobe
//   resp_rdata [DATA_W]       : read data, pass-through of ram_dout
//   ram_en/we/addr/din/dout   : RAM port
module iob_ram_tdp_arb
  import iob_ram_tdp_arb_pkg::*;
#(
  parameter int N_REQ  = DEF_N_REQ,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  output logic [N_REQ-1:0]          req_ready,
  input  logic [N_REQ-1:0]          req_we,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  input  logic [N_REQ*DATA_W-1:0]   req_wdata,
`ifdef IOB_RAM_TDP_ARB_LOCK_EN
  input  logic [N_REQ-1:0]          req_lock,
`endif
  output logic [N_REQ-1:0]          resp_valid,
  output logic [DATA_W-1:0]         resp_rdata,
  output logic                      ram_en,
  output logic                      ram_we,
  output logic [ADDR_W-1:0]         ram_addr,
  output logic [DATA_W-1:0]         ram_din,
  input  logic [DATA_W-1:0]         ram_dout
);

  localparam int IDX_W = idx_width(N_REQ);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [N_REQ-1:0] resp_valid_q, resp_valid_d;

  logic [N_REQ-1:0] eligible;
  logic [N_REQ-1:0] gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_any;
  logic [IDX_W-1:0] ptr_next;

`ifdef IOB_RAM_TDP_ARB_LOCK_EN
  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [N_REQ-1:0] owner_mask;
`endif

  // Requests that may compete this cycle. Reset blocks everything; while
  // locked only the owner is visible to the selector.
  always_comb begin
    eligible = req_valid;
`ifdef IOB_RAM_TDP_ARB_LOCK_EN
    owner_mask          = '0;
    owner_mask[owner_q] = 1'b1;
    if (state_q == ARB_LOCKED) begin
      eligible = req_valid & owner_mask;
    end
`endif
    if (rst) begin
      eligible = '0;
    end
  end

  iob_rr_sel #(
    .N     (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_sel (
    .req (eligible),
    .ptr (ptr_q),
    .gnt (gnt),
    .idx (gnt_idx),
    .any (gnt_any)
  );

  assign req_ready = gnt;

  // RAM port follows the granted requester; idle port is driven to zero.
  always_comb begin
    ram_en   = 1'b0;
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_din  = '0;
    if (gnt_any) begin
      ram_en   = 1'b1;
      ram_we   = req_we[gnt_idx];
      ram_addr = req_addr[gnt_idx*ADDR_W +: ADDR_W];
      ram_din  = req_wdata[gnt_idx*DATA_W +: DATA_W];
    end
  end

  // Next state: response strobe, pointer and optional lock FSM.
  always_comb begin
    resp_valid_d = gnt & ~req_we;
    ptr_next     = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + IDX_W'(1);
    ptr_d        = ptr_q;
`ifdef IOB_RAM_TDP_ARB_LOCK_EN
    state_d = state_q;
    owner_d = owner_q;
    case (state_q)
      ARB_IDLE: begin
        if (gnt_any) begin
          ptr_d = ptr_next;
          if (req_lock[gnt_idx]) begin
            state_d = ARB_LOCKED;
            owner_d = gnt_idx;
          end
        end
      end
      ARB_LOCKED: begin
        // Transfers made while the lock is still held leave ptr alone so
        // the burst does not skew the rotation for everyone else.
        if (!req_lock[owner_q]) begin
          state_d = ARB_IDLE;
          if (gnt_any) begin
            ptr_d = ptr_next;
          end
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
`else
    if (gnt_any) begin
      ptr_d = ptr_next;
    end
`endif
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q        <= '0;
      resp_valid_q <= '0;
`ifdef IOB_RAM_TDP_ARB_LOCK_EN
      state_q      <= ARB_IDLE;
      owner_q      <= '0;
`endif
    end else begin
      ptr_q        <= ptr_d;
      resp_valid_q <= resp_valid_d;
`ifdef IOB_RAM_TDP_ARB_LOCK_EN
      state_q      <= state_d;
      owner_q      <= owner_d;
`endif
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_rdata = ram_dout;

endmodule

// File: tb/tb_iob_ram_tdp_arb.sv
// tb_iob_ram_tdp_arb
// Bench for iob_ram_tdp_arb with N_REQ=2, DATA_W=8, ADDR_W=4, driving a
// behavioural registered-output RAM. A negedge monitor keeps its own
// arbitration/memory model and a queue of expected read responses.
// Define IOB_RAM_TDP_ARB_LOCK_EN to also exercise the lock sequence.
module tb_iob_ram_tdp_arb;

  localparam int N_REQ  = 2;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_ready;
  logic [1:0]  req_we = '0;
  logic [7:0]  req_addr = '0;
  logic [15:0] req_wdata = '0;
`ifdef IOB_RAM_TDP_ARB_LOCK_EN
  logic [1:0]  req_lock = '0;
`endif
  logic [1:0]  resp_valid;
  logic [7:0]  resp_rdata;
  logic        ram_en;
  logic        ram_we;
  logic [3:0]  ram_addr;
  logic [7:0]  ram_din;
  logic [7:0]  ram_dout = '0;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int         cyc;
    logic [1:0] vld;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    logic [1:0] v;
    logic [1:0] w;
    logic [3:0] a;
    logic [7:0] d;
    logic [1:0] exp_rdy;
  } vec_t;

  vec_t vecs[9];

  logic [7:0] ram_mem [16] = '{default: 8'h00};
  logic [7:0] mem_m   [16] = '{default: 8'h00};

  iob_ram_tdp_arb #(
    .N_REQ  (N_REQ),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
`ifdef IOB_RAM_TDP_ARB_LOCK_EN
    .req_lock   (req_lock),
`endif
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .ram_en     (ram_en),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_din    (ram_din),
    .ram_dout   (ram_dout)
  );

  always #5 clk = ~clk;

  // Registered-output RAM port, read-before-write.
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) ram_mem[ram_addr] <= ram_din;
      ram_dout <= ram_mem[ram_addr];
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] v, input logic [1:0] w,
                               input logic [3:0] a0, input logic [3:0] a1,
                               input logic [7:0] d0, input logic [7:0] d1);
    req_valid = v;
    req_we    = w;
    req_addr  = {a1, a0};
    req_wdata = {d1, d0};
    #2;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Monitor: mid-cycle, compare handshake and response against the model,
  // then advance the model as the coming clock edge will.
  logic [0:0] mptr = 1'b0;
  logic [1:0] m_eff;
  logic [1:0] m_gnt;
  int         m_g;
  logic [3:0] m_addr;
  exp_t       m_e;
`ifdef IOB_RAM_TDP_ARB_LOCK_EN
  logic       m_locked = 1'b0;
  int         m_owner  = 0;
`endif

  always @(negedge clk) begin
    m_eff = rst ? 2'b00 : req_valid;
`ifdef IOB_RAM_TDP_ARB_LOCK_EN
    if (m_locked) m_eff = m_eff & (2'b01 << m_owner);
`endif
    m_gnt = 2'b00;
    m_g   = -1;
    for (int k = 0; k < 2; k++) begin
      if (m_g < 0 && m_eff[(int'(mptr) + k) % 2]) begin
        m_g = (int'(mptr) + k) % 2;
        m_gnt[m_g] = 1'b1;
      end
    end
    checkOutput("mon_ready", {30'd0, req_ready}, {30'd0, m_gnt});
    checkOutput("mon_ram_en", {31'd0, ram_en}, {31'd0, |m_gnt});

    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      m_e = sb.pop_front();
      checkOutput("mon_resp_valid", {30'd0, resp_valid}, {30'd0, m_e.vld});
      checkOutput("mon_resp_rdata", {24'd0, resp_rdata}, {24'd0, m_e.data});
    end else begin
      checkOutput("mon_resp_idle", {30'd0, resp_valid}, 32'd0);
    end

    if (rst) begin
      mptr = 1'b0;
`ifdef IOB_RAM_TDP_ARB_LOCK_EN
      m_locked = 1'b0;
`endif
    end else begin
      if (m_g >= 0) begin
        m_addr = req_addr[m_g*4 +: 4];
        if (req_we[m_g]) mem_m[m_addr] = req_wdata[m_g*8 +: 8];
        else sb.push_back('{cyc + 1, m_gnt, mem_m[m_addr]});
      end
`ifdef IOB_RAM_TDP_ARB_LOCK_EN
      if (!m_locked) begin
        if (m_g >= 0) begin
          mptr = 1'((m_g + 1) % 2);
          if (req_lock[m_g]) begin
            m_locked = 1'b1;
            m_owner  = m_g;
          end
        end
      end else if (!req_lock[m_owner]) begin
        m_locked = 1'b0;
        if (m_g >= 0) mptr = 1'((m_g + 1) % 2);
      end
`else
      if (m_g >= 0) mptr = 1'((m_g + 1) % 2);
`endif
    end
    cyc++;
  end

  initial begin
    int g;

    // Rows run straight after reset, so the pointer starts at requester 0.
    // Requester 1 uses address a+1 and data d+1.
    vecs[0] = '{2'b11, 2'b00, 4'd3, 8'd0,  2'b01};
    vecs[1] = '{2'b11, 2'b00, 4'd3, 8'd0,  2'b10};
    vecs[2] = '{2'b11, 2'b00, 4'd3, 8'd0,  2'b01};
    vecs[3] = '{2'b11, 2'b00, 4'd3, 8'd0,  2'b10};
    vecs[4] = '{2'b10, 2'b10, 4'd7, 8'd55, 2'b10};
    vecs[5] = '{2'b01, 2'b00, 4'd8, 8'd0,  2'b01};
    vecs[6] = '{2'b00, 2'b00, 4'd0, 8'd0,  2'b00};
    vecs[7] = '{2'b11, 2'b11, 4'd0, 8'd9,  2'b10};
    vecs[8] = '{2'b11, 2'b11, 4'd0, 8'd9,  2'b01};

    // Reset with a request pending: nothing may be granted.
    rst = 1'b1;
    applyStimulus(2'b11, 2'b00, 4'd1, 4'd2, 8'd0, 8'd0);
    checkOutput("rst_ready", {30'd0, req_ready}, 32'd0);
    checkOutput("rst_ram_en", {31'd0, ram_en}, 32'd0);
    nextCycle();
    nextCycle();
    checkOutput("rst_resp", {30'd0, resp_valid}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].v, vecs[i].w, vecs[i].a, vecs[i].a + 4'd1,
                    vecs[i].d, vecs[i].d + 8'd1);
      checkOutput("tbl_ready", {30'd0, req_ready}, {30'd0, vecs[i].exp_rdy});
      if (vecs[i].exp_rdy != 2'b00) begin
        g = vecs[i].exp_rdy[1] ? 1 : 0;
        checkOutput("tbl_ram_we", {31'd0, ram_we}, {31'd0, vecs[i].w[g]});
        checkOutput("tbl_ram_addr", {28'd0, ram_addr}, {28'd0, vecs[i].a + 4'(g)});
        if (vecs[i].w[g]) checkOutput("tbl_ram_din", {24'd0, ram_din}, {24'd0, vecs[i].d + 8'(g)});
      end else begin
        checkOutput("tbl_idle_addr", {28'd0, ram_addr}, 32'd0);
        checkOutput("tbl_idle_we", {31'd0, ram_we}, 32'd0);
      end
      nextCycle();
    end

    // Ten idle cycles; the pointer (now at requester 1) must hold.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(2'b00, 2'b00, 4'd0, 4'd0, 8'd0, 8'd0);
      checkOutput("idle_ready", {30'd0, req_ready}, 32'd0);
      checkOutput("idle_ram_en", {31'd0, ram_en}, 32'd0);
      if (i > 0) checkOutput("idle_resp", {30'd0, resp_valid}, 32'd0);
      nextCycle();
    end
    applyStimulus(2'b11, 2'b00, 4'd3, 4'd3, 8'd0, 8'd0);
    checkOutput("idle_ptr_held", {30'd0, req_ready}, 32'd2);
    nextCycle();

    // Requester 0 alone: fill all 16 words, then read them back.
    for (int i = 0; i < 16; i++) begin
      applyStimulus(2'b01, 2'b01, 4'(i), 4'd0, 8'(32 + i), 8'd0);
      nextCycle();
    end
    for (int i = 0; i < 16; i++) begin
      applyStimulus(2'b01, 2'b00, 4'(i), 4'd0, 8'd0, 8'd0);
      nextCycle();
      checkOutput("fill_resp_valid", {30'd0, resp_valid}, 32'd1);
      checkOutput("fill_resp_rdata", {24'd0, resp_rdata}, 32'(32 + i));
    end

    // Write by requester 1 immediately followed by a read by requester 0.
    applyStimulus(2'b10, 2'b10, 4'd0, 4'd5, 8'd0, 8'h40);
    nextCycle();
    applyStimulus(2'b01, 2'b00, 4'd5, 4'd0, 8'd0, 8'd0);
    nextCycle();
    applyStimulus(2'b00, 2'b00, 4'd0, 4'd0, 8'd0, 8'd0);
    checkOutput("wr_rd_valid", {30'd0, resp_valid}, 32'd1);
    checkOutput("wr_rd_data", {24'd0, resp_rdata}, 32'h40);
    nextCycle();

    // Reset in the middle of traffic.
    applyStimulus(2'b01, 2'b00, 4'd2, 4'd0, 8'd0, 8'd0);
    nextCycle();
    rst = 1'b1;
    applyStimulus(2'b11, 2'b00, 4'd3, 4'd3, 8'd0, 8'd0);
    checkOutput("mid_rst_ready", {30'd0, req_ready}, 32'd0);
    nextCycle();
    rst = 1'b0;
    applyStimulus(2'b11, 2'b00, 4'd3, 4'd3, 8'd0, 8'd0);
    checkOutput("mid_rst_resp", {30'd0, resp_valid}, 32'd0);
    checkOutput("mid_rst_grant", {30'd0, req_ready}, 32'd1);
    nextCycle();
    applyStimulus(2'b00, 2'b00, 4'd0, 4'd0, 8'd0, 8'd0);
    nextCycle();

`ifdef IOB_RAM_TDP_ARB_LOCK_EN
    // Pointer is at requester 1, so it wins, locks, and bursts four reads
    // while requester 0 waits with a steady request.
    req_lock = 2'b10;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(2'b11, 2'b00, 4'd9, 4'(i), 8'd0, 8'd0);
      checkOutput("lock_burst", {30'd0, req_ready}, 32'd2);
      nextCycle();
    end
    req_lock = 2'b00;
    applyStimulus(2'b01, 2'b00, 4'd9, 4'd0, 8'd0, 8'd0);
    checkOutput("lock_release_cycle", {30'd0, req_ready}, 32'd0);
    nextCycle();
    applyStimulus(2'b01, 2'b00, 4'd9, 4'd0, 8'd0, 8'd0);
    checkOutput("lock_after_release", {30'd0, req_ready}, 32'd1);
    nextCycle();
    applyStimulus(2'b00, 2'b00, 4'd0, 4'd0, 8'd0, 8'd0);
    nextCycle();
`endif

    nextCycle();
    nextCycle();
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL sb_drain: got %0d pending expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
